// File: rtl/neural_frame_serializer.sv
// rtl/neural_frame_serializer.sv - captures a multi-channel frame and streams its enabled channels
// Masked channels are skipped by a priority encoder, so a k-channel frame costs k beats.
module neural_frame_serializer #(
   parameter int NUM_CHANNELS  = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int CH_ID_WIDTH   = $clog2(NUM_CHANNELS),
   parameter int SEQ_WIDTH     = 8,
   parameter int OVR_CNT_WIDTH = 16
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic [NUM_CHANNELS-1:0]  channel_mask,
   input  logic [DATA_WIDTH-1:0]    frame_data_in [NUM_CHANNELS],
   input  logic                     frame_valid_in,
   output logic                     frame_ready_out,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [CH_ID_WIDTH-1:0]   out_channel,
   output logic [SEQ_WIDTH-1:0]     out_seq,
   output logic                     out_sof,
   output logic                     out_eof,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic [OVR_CNT_WIDTH-1:0] overrun_count
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                   state_q, state_d;
   logic [CH_ID_WIDTH-1:0]   ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0]    shadow_q [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]    shadow_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  mask_q, mask_d;
   logic [SEQ_WIDTH-1:0]     seq_q, seq_d;
   logic [OVR_CNT_WIDTH-1:0] ovr_q, ovr_d;
   logic                     ready_q, ready_d;
   logic                     busy_q, busy_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_sof_q, out_sof_d;
   logic                     out_eof_q, out_eof_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [CH_ID_WIDTH-1:0]   out_channel_q, out_channel_d;
   logic [SEQ_WIDTH-1:0]     out_seq_q, out_seq_d;

   logic                     accept;
   logic [CH_ID_WIDTH-1:0]   first_ptr, next_ptr;
   logic                     first_is_last, next_is_last;

   function automatic logic [CH_ID_WIDTH-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] v);
      lowest_set = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = CH_ID_WIDTH'(i);
      end
   endfunction

   // Bits strictly above position p.
   function automatic logic [NUM_CHANNELS-1:0] above(input logic [CH_ID_WIDTH-1:0] p);
      above = ~((NUM_CHANNELS'(2) << p) - NUM_CHANNELS'(1));
   endfunction

   assign accept        = frame_valid_in && ready_q;
   assign first_ptr     = lowest_set(channel_mask);
   assign first_is_last = (channel_mask & above(first_ptr)) == '0;
   assign next_ptr      = lowest_set(mask_q & above(ptr_q));
   assign next_is_last  = (mask_q & above(next_ptr)) == '0;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      shadow_d      = shadow_q;
      mask_d        = mask_q;
      seq_d         = seq_q;
      ovr_d         = ovr_q;
      out_valid_d   = out_valid_q;
      out_sof_d     = out_sof_q;
      out_eof_d     = out_eof_q;
      out_data_d    = out_data_q;
      out_channel_d = out_channel_q;
      out_seq_d     = out_seq_q;

      if (state_q == SWEEP && frame_valid_in && ovr_q != '1) begin
         ovr_d = ovr_q + OVR_CNT_WIDTH'(1);
      end

      if (accept) begin
         shadow_d = frame_data_in;
         mask_d   = channel_mask;
         seq_d    = seq_q + SEQ_WIDTH'(1);
         // An all-zero mask still burns a sequence number but produces no beats.
         if (channel_mask != '0) begin
            state_d       = SWEEP;
            ptr_d         = first_ptr;
            out_valid_d   = 1'b1;
            out_sof_d     = 1'b1;
            out_eof_d     = first_is_last;
            out_data_d    = frame_data_in[first_ptr];
            out_channel_d = first_ptr;
            out_seq_d     = seq_q;
         end
      end else if (state_q == SWEEP && out_ready) begin
         if (out_eof_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
         end else begin
            ptr_d         = next_ptr;
            out_sof_d     = 1'b0;
            out_eof_d     = next_is_last;
            out_data_d    = shadow_q[next_ptr];
            out_channel_d = next_ptr;
         end
      end

      ready_d = (state_d == IDLE);
      busy_d  = (state_d == SWEEP);
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         shadow_q      <= '{default: '0};
         mask_q        <= '0;
         seq_q         <= '0;
         ovr_q         <= '0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_sof_q     <= 1'b0;
         out_eof_q     <= 1'b0;
         out_data_q    <= '0;
         out_channel_q <= '0;
         out_seq_q     <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         shadow_q      <= shadow_d;
         mask_q        <= mask_d;
         seq_q         <= seq_d;
         ovr_q         <= ovr_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         out_valid_q   <= out_valid_d;
         out_sof_q     <= out_sof_d;
         out_eof_q     <= out_eof_d;
         out_data_q    <= out_data_d;
         out_channel_q <= out_channel_d;
         out_seq_q     <= out_seq_d;
      end
   end

   assign frame_ready_out = ready_q;
   assign busy            = busy_q;
   assign out_valid       = out_valid_q;
   assign out_sof         = out_sof_q;
   assign out_eof         = out_eof_q;
   assign out_data        = out_data_q;
   assign out_channel     = out_channel_q;
   assign out_seq         = out_seq_q;
   assign overrun_count   = ovr_q;

endmodule

// File: tb/tb_neural_frame_serializer.sv
// tb/tb_neural_frame_serializer.sv - directed table-driven bench for neural_frame_serializer
module tb_neural_frame_serializer;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic [15:0] channel_mask;
   logic [15:0] fdata [16];
   logic        frame_valid_in;
   logic        frame_ready_out;
   logic [15:0] out_data;
   logic [3:0]  out_channel;
   logic [7:0]  out_seq;
   logic        out_sof, out_eof, out_valid;
   logic        out_ready;
   logic        busy;
   logic [3:0]  overrun_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] mask;
      logic [15:0] salt;
      bit          stall;
      int          ovr_cycles;
      logic [7:0]  exp_seq;
      logic [15:0] exp_ovr;
   } vec_t;

   vec_t vecs [8];

   always #5 sys_clk = ~sys_clk;

   neural_frame_serializer #(.OVR_CNT_WIDTH(4)) dut (
      .sys_clk         (sys_clk),
      .rst             (rst),
      .channel_mask    (channel_mask),
      .frame_data_in   (fdata),
      .frame_valid_in  (frame_valid_in),
      .frame_ready_out (frame_ready_out),
      .out_data        (out_data),
      .out_channel     (out_channel),
      .out_seq         (out_seq),
      .out_sof         (out_sof),
      .out_eof         (out_eof),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy),
      .overrun_count   (overrun_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic run_frame(input logic [15:0] mask, input logic [15:0] salt, input bit stall,
                            input int ovr_cycles, input logic [7:0] exp_seq, input logic [15:0] exp_ovr);
      int    chans[$];
      int    idx;
      int    cyc;
      bit    rdy;
      logic [63:0] exp;
      for (int i = 0; i < 16; i++) if (mask[i]) chans.push_back(i);
      cyc = 0;
      while (!frame_ready_out && cyc < 20) begin
         step();
         cyc++;
      end
      chk("ready_before_accept", 64'(frame_ready_out), 64'd1);
      channel_mask = mask;
      for (int i = 0; i < 16; i++) fdata[i] = 16'(i * 257) ^ salt;
      frame_valid_in = 1'b1;
      step();
      frame_valid_in = 1'b0;
      channel_mask = ~mask;
      for (int i = 0; i < 16; i++) fdata[i] = 16'hDEAD;
      if (ovr_cycles > 0) begin
         out_ready = 1'b0;
         frame_valid_in = 1'b1;
         repeat (ovr_cycles) step();
         frame_valid_in = 1'b0;
      end
      idx = 0;
      cyc = 0;
      while (idx < chans.size() && cyc < 200) begin
         rdy = stall ? (cyc % 3 == 0) : 1'b1;
         out_ready = rdy;
         exp = {31'd0, 1'b1, 1'b0, 1'b1, 1'(idx == 0), 1'(idx == chans.size() - 1),
                exp_seq, 4'(chans[idx]), 16'(chans[idx] * 257) ^ salt};
         chk("beat", {31'd0, busy, frame_ready_out, out_valid, out_sof, out_eof, out_seq, out_channel, out_data}, exp);
         step();
         if (rdy) idx++;
         cyc++;
      end
      chk("beats_completed", 64'(idx), 64'(chans.size()));
      out_ready = 1'b1;
      chk("idle_after_frame", {59'd0, out_valid, busy, frame_ready_out, out_sof, out_eof}, 64'b00100);
      chk("overrun_count", 64'(overrun_count), 64'(exp_ovr));
   endtask

   initial begin
      vecs[0] = '{16'hFFFF, 16'h0000, 1'b0, 0,  8'd0, 16'd0};
      vecs[1] = '{16'h8421, 16'h1234, 1'b0, 0,  8'd1, 16'd0};
      vecs[2] = '{16'h0010, 16'h5A5A, 1'b0, 0,  8'd2, 16'd0};
      vecs[3] = '{16'h0000, 16'h0F0F, 1'b0, 0,  8'd3, 16'd0};
      vecs[4] = '{16'h00FF, 16'hC3C3, 1'b1, 0,  8'd4, 16'd0};
      vecs[5] = '{16'h0001, 16'h7777, 1'b0, 0,  8'd5, 16'd0};
      vecs[6] = '{16'h00F0, 16'h1111, 1'b0, 3,  8'd6, 16'd3};
      vecs[7] = '{16'h0F00, 16'h2222, 1'b0, 20, 8'd7, 16'd15};

      rst = 1'b1;
      channel_mask = '0;
      for (int i = 0; i < 16; i++) fdata[i] = '0;
      frame_valid_in = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      chk("reset_outputs", {busy, frame_ready_out, out_valid, out_sof, out_eof, out_seq, out_channel, out_data, overrun_count}, 64'd0);
      rst = 1'b0;
      step();
      chk("ready_after_reset", 64'(frame_ready_out), 64'd1);

      for (int v = 0; v < 8; v++) begin
         run_frame(vecs[v].mask, vecs[v].salt, vecs[v].stall, vecs[v].ovr_cycles, vecs[v].exp_seq, vecs[v].exp_ovr);
      end

      channel_mask = 16'hFFFF;
      for (int i = 0; i < 16; i++) fdata[i] = 16'(i * 257);
      out_ready = 1'b1;
      frame_valid_in = 1'b1;
      step();
      frame_valid_in = 1'b0;
      chk("mid_first_seq", 64'(out_seq), 64'd8);
      repeat (4) step();
      chk("mid_before_reset", {out_valid, out_channel, out_data}, {43'd0, 1'b1, 4'd4, 16'h0404});
      rst = 1'b1;
      step();
      chk("mid_reset", {busy, frame_ready_out, out_valid, out_sof, out_eof, out_seq, out_channel, out_data, overrun_count}, 64'd0);
      rst = 1'b0;
      step();
      chk("ready_after_mid_reset", {out_valid, frame_ready_out}, 64'b01);
      run_frame(16'h0300, 16'h00AA, 1'b0, 0, 8'd0, 16'd0);
      run_frame(16'h8001, 16'h0055, 1'b1, 0, 8'd1, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
